// File: rtl/sdram_req_arbiter_pkg.sv
// Shared definitions for the SDRAM request arbiter.
// Contents: sequencer state encoding, requester port indices and the word
// returned to a requester when a read times out (ARB_TIMEOUT_EN builds).
package sdram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_req_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports:
//   req[1:0]  request vector (bit n = port n)
//   last_gnt  port granted most recently
//   gnt_valid at least one request present
//   gnt       chosen port; on a tie the port that was not granted last wins
module rr_arb2
  import sdram_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |req;
    gnt       = PORT0;
    unique case (req)
      2'b01:   gnt = PORT0;
      2'b10:   gnt = PORT1;
      2'b11:   gnt = ~last_gnt;
      default: gnt = PORT0;
    endcase
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: two-requester arbiter/sequencer in front of
// sdram_controller. Port 0 is the Wishbone path, port 1 the prefetch/DMA
// path. Exactly one transaction is in flight; contention is resolved
// round-robin and read data is returned only to the owning port.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mN_req/we/addr/wdata requester N request (level, held until completion)
//   mN_ack               write accepted (combinational pulse)
//   mN_rvalid/rdata      read data valid pulse and held read-data register
//   m_err                read timed out; qualifies the rvalid pulse
//   ctrl_*               controller handshake (in_valid/rw/addr/wdata out,
//                        busy/out_valid/rdata in)
//
// Build option: define ARB_TIMEOUT_EN to enable the read watchdog
// (TIMEOUT_CYC cycles in WAIT_RD, then return TIMEOUT_DATA with m_err=1).
module sdram_req_arbiter
  import sdram_req_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m_err,
  output logic              ctrl_in_valid,
  output logic              ctrl_rw,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid,
  input  logic [DATA_W-1:0] ctrl_rdata
);

  // The watchdog counter is 8 bits wide.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..256");
  end

  arb_state_t        state, next_state;
  logic              last_gnt;
  logic              owner;
  logic              txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              gnt_valid, gnt;
  logic              timeout_hit;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  assign timeout_hit = (state == WAIT_RD) && !ctrl_out_valid &&
                       (wait_cnt == 8'(TIMEOUT_CYC - 1));

  // Held at zero outside WAIT_RD, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == WAIT_RD) begin
        wait_cnt <= wait_cnt + 8'd1;
        err_q    <= timeout_hit;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register plus transaction/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= PORT1;
      owner     <= PORT0;
      txn_we    <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && gnt_valid) begin
        owner     <= gnt;
        last_gnt  <= gnt;
        txn_we    <= (gnt == PORT1) ? m1_we    : m0_we;
        txn_addr  <= (gnt == PORT1) ? m1_addr  : m0_addr;
        txn_wdata <= (gnt == PORT1) ? m1_wdata : m0_wdata;
      end
      if (state == WAIT_RD && (ctrl_out_valid || timeout_hit)) begin
        if (owner == PORT1) begin
          rdata1 <= ctrl_out_valid ? ctrl_rdata : DATA_W'(TIMEOUT_DATA);
        end else begin
          rdata0 <= ctrl_out_valid ? ctrl_rdata : DATA_W'(TIMEOUT_DATA);
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gnt_valid) next_state = ISSUE;
      ISSUE:   if (!ctrl_busy) next_state = txn_we ? IDLE : WAIT_RD;
      WAIT_RD: if (ctrl_out_valid || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ctrl_in_valid = (state == ISSUE);
    ctrl_rw       = txn_we;
    ctrl_addr     = txn_addr;
    ctrl_wdata    = txn_wdata;
    m0_ack        = (state == ISSUE) && !ctrl_busy && txn_we && (owner == PORT0);
    m1_ack        = (state == ISSUE) && !ctrl_busy && txn_we && (owner == PORT1);
    m0_rvalid     = (state == RESP) && (owner == PORT0);
    m1_rvalid     = (state == RESP) && (owner == PORT1);
    m0_rdata      = rdata0;
    m1_rdata      = rdata1;
`ifdef ARB_TIMEOUT_EN
    m_err         = (state == RESP) && err_q;
`else
    m_err         = 1'b0;
`endif
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
Two-requester arbiter and sequencer in front of sdram_controller. Port 0 is the Wishbone path; port 1 is the prefetch/DMA path, for example a code-cache line fill. It serialises accesses with exactly one transaction in flight, and drives the controller's in_valid/rw/busy/out_valid handshake. Round-robin grant on contention; read data is returned only to the owner.

Parameters:
ADDR_W, 23, requester/controller address width
DATA_W, 32, data width
TIMEOUT_CYC, 64, read watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
m0_req  in  1  port 0 request; level, held until m0_ack (write) or m0_rvalid (read)
m0_we  in  1  1=write, 0=read; stable while m0_req
m0_addr  in  ADDR_W  address
m0_wdata  in  DATA_W  write data
m0_ack  out  1  write accepted (combinational pulse)
m0_rvalid  out  1  read data valid (registered pulse)
m0_rdata  out  DATA_W  read data
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata  same as port 0
m_err  out  1  timeout flag, qualifies the rvalid pulse
ctrl_in_valid  out  1  to controller in_valid
ctrl_rw  out  1  to controller rw
ctrl_addr  out  ADDR_W  to controller user_addr
ctrl_wdata  out  DATA_W  to controller data_in
ctrl_busy  in  1  controller busy
ctrl_out_valid  in  1  controller read-data valid
ctrl_rdata  in  DATA_W  controller data_out

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, last_gnt=1 so port 0 wins the first tie. All outputs 0; rdata registers 0. Reset aborts any in-flight transaction. No ack/rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE, no request: stay.
- IDLE, request(s) present: pick the owner.
  - Only one req high: that port.
  - Both high: the port != last_gnt.
  - Register owner, we, addr, wdata into txn regs. Set last_gnt=owner. Go to ISSUE.
- ISSUE: ctrl_in_valid=1; ctrl_rw/addr/wdata driven from txn regs.
  - ctrl_busy=1: hold ISSUE, keep all outputs stable.
  - ctrl_busy=0 and write: owner ack=1 this cycle, go to IDLE.
  - ctrl_busy=0 and read: go to WAIT_RD.
- WAIT_RD: ctrl_in_valid=0.
  - On ctrl_out_valid: capture ctrl_rdata into owner's rdata reg, go to RESP.
  - ctrl_out_valid in any other state is ignored.
- RESP: owner rvalid=1 for exactly one cycle; non-owner rdata is unchanged. Go to IDLE.
- Latency:
  - Write, ctrl idle: req to ack = 2 cycles.
  - Read: rvalid = 2 cycles after ctrl_out_valid was seen in WAIT_RD.
- Requester rule: drop req at the edge after ack/rvalid. The arbiter re-samples req only in IDLE, so no double grant.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…
- A request that arrives while another transaction is active waits; it is never dropped.
- Non-owner ack/rvalid stay 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to WAIT_RD and increments each WAIT_RD cycle.
  - When count reaches TIMEOUT_CYC-1 without ctrl_out_valid: load owner rdata=32'hDEAD_BEEF, go to RESP with m_err=1 during the rvalid pulse.
  - A late ctrl_out_valid arriving after the timeout is ignored.
- Undefined: no counter; WAIT_RD waits indefinitely; m_err tied 0.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_RD=2'd2, RESP=2'd3), port index constants, the TIMEOUT_DATA constant 32'hDEAD_BEEF.
- One natural sub-module, rr_arb2: combinational 2-way round-robin pick from req[1:0] and last_gnt. Everything else stays in the top.

Test Plan:
- m0 write addr=23'h10 data=32'h1234_5678, ctrl_busy=0 → ctrl_in_valid for 1 cycle with ctrl_rw=1, ctrl_addr=23'h10; m0_ack on the 2nd cycle after req; m1 outputs quiet.
- m1 read addr=23'h40; ctrl_out_valid 5 cycles later with ctrl_rdata=32'hCAFE_F00D → m1_rvalid 1-cycle pulse, m1_rdata=32'hCAFE_F00D, m0_rvalid=0.
- m0 and m1 both read from reset, held through 4 transactions → grant order 0,1,0,1; never two ctrl_in_valid pulses without an intervening out_valid.
- ctrl_busy held high 3 cycles during an m0 write → ctrl_in_valid/addr/wdata stable for all 4 cycles; m0_ack only in the cycle busy falls.
- rst asserted in WAIT_RD, then ctrl_out_valid → no rvalid; state=IDLE; next request proceeds normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=64, no ctrl_out_valid → rvalid with m_err=1 and rdata=32'hDEAD_BEEF; a late out_valid is ignored.
